// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for serial_adder
package serial_adder_pkg;

`include "serial_adder_defs.vh"

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_defs.vh
// rtl/serial_adder_defs.vh - state encoding and bit-counter width for serial_adder
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH

localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_RUN  = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;

// Bit counter must hold 0..WIDTH-1; a 1-bit operand still gets a 1-bit counter
function automatic int unsigned sa_cnt_width(input int unsigned w);
    if (w <= 1) return 1;
    return $clog2(w);
endfunction

`endif

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder reusing one full_adder over WIDTH cycles
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = int'(sa_cnt_width(WIDTH));

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;
    logic             w_accept;

    full_adder u_cell (
        .i_a    (r_sh_a[0]),
        .i_b    (r_sh_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // Accumulator shifts right with the new sum bit arriving at the MSB
    generate
        if (WIDTH == 1) begin : g_acc_one
            assign w_acc_next = w_fa_sum;
        end else begin : g_acc_many
            assign w_acc_next = {w_fa_sum, r_acc[WIDTH-1:1]};
        end
    endgenerate

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = start && (r_state != RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE can re-arm immediately for back-to-back adds
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand load, per-bit shifting and result capture on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_sh_a  <= operand_A;
            r_sh_b  <= operand_B;
            r_carry <= carry_in;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sh_a  <= r_sh_a >> 1;
            r_sh_b  <= r_sh_b >> 1;
            r_acc   <= w_acc_next;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic       a1;
    logic       b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic       sum1;
    logic       cout1;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_sum;
    logic       m_cout;

    vec_t vecs[7];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .operand_A (op_a),
        .operand_B (op_b),
        .carry_in  (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .operand_A (a1),
        .operand_B (b1),
        .carry_in  (cin1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (cout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One addition on the 8-bit instance: latency, busy, result hold, result
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                          input logic [7:0] es, input logic ec, input string name);
        int n;
        bit busy_ok;
        bit held;
        @(negedge clk);
        op_a = ia; op_b = ib; cin = icin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
        n = 0; busy_ok = 1; held = 1;
        while (n < 40) begin
            @(negedge clk);
            if (done) break;
            if (!busy) busy_ok = 0;
            if (sum !== m_sum || cout !== m_cout) held = 0;
            n++;
        end
        check({name, " latency"}, n, 8);
        check({name, " busy"}, {31'd0, busy_ok}, 1);
        check({name, " hold"}, {31'd0, held}, 1);
        check({name, " sum"}, {24'd0, sum}, {24'd0, es});
        check({name, " cout"}, {31'd0, cout}, {31'd0, ec});
        m_sum = es; m_cout = ec;
    endtask

    // One addition on the 1-bit instance
    task automatic run_op1(input logic ia, input logic ib, input logic ic);
        int n;
        logic [1:0] exp;
        exp = 2'(ia) + 2'(ib) + 2'(ic);
        @(negedge clk);
        a1 = ia; b1 = ib; cin1 = ic; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (done1) break;
            n++;
        end
        check("w1 latency", n, 1);
        check("w1 sum", {31'd0, sum1}, {31'd0, exp[0]});
        check("w1 cout", {31'd0, cout1}, {31'd0, exp[1]});
    endtask

    initial begin
        int n;
        int stray;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rexp;

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{8'h10, 8'h01, 1'b0, 8'h11, 1'b0};

        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        m_sum = '0; m_cout = 1'b0;

        #12;
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset sum", {24'd0, sum}, 0);
        check("reset cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            rexp = 9'(ra) + 9'(rb) + 9'(rc);
            run_op(ra, rb, rc, rexp[7:0], rexp[8], $sformatf("rnd%0d", i));
        end

        // Start held high through RUN, then re-accepted in the DONE cycle
        @(negedge clk);
        op_a = 8'h10; op_b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        op_a = 8'hAA; op_b = 8'h55;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        check("b2b first latency", n, 8);
        check("b2b first sum", {24'd0, sum}, 32'h11);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b no idle gap", {31'd0, busy}, 1);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        check("b2b second latency", n, 8);
        check("b2b second sum", {24'd0, sum}, 32'hFF);
        check("b2b second cout", {31'd0, cout}, 0);
        m_sum = 8'hFF; m_cout = 1'b0;

        // Asynchronous reset in the middle of an addition
        @(negedge clk);
        op_a = 8'h77; op_b = 8'h11; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, busy}, 0);
        check("async rst done", {31'd0, done}, 0);
        check("async rst sum", {24'd0, sum}, 0);
        check("async rst cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_sum = '0; m_cout = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("no done after abort", stray, 0);
        run_op(8'h77, 8'h11, 1'b0, 8'h88, 1'b0, "after reset");

        // WIDTH=1 instance over every input combination
        for (int v = 0; v < 8; v++) begin
            run_op1(v[2], v[1], v[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
